// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage forwarding selects, load-use stall and a saturating stall-cycle counter.
// Define HAZARD_R30_GUARD_EN to exclude hardwired R30 from forwarding and stalls.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             UseRs,
  input  logic             UseRt,
  input  logic [4:0]       Rd_EX,
  input  logic [4:0]       Rd_MEM,
  input  logic [4:0]       Rd_WB,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_MEM,
  input  logic             RegWrite_WB,
  input  logic             MemRead_EX,
  input  logic             RPzero_EX,
  input  logic             RPzero_MEM,
  input  logic             RPzero_WB,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);
`ifdef HAZARD_R30_GUARD_EN
  localparam bit R30_GUARD = 1'b1;
`else
  localparam bit R30_GUARD = 1'b0;
`endif
  logic v_ex, v_mem, v_wb;
  assign v_ex  = RegWrite_EX  && !RPzero_EX  && |Rd_EX  && !(R30_GUARD && Rd_EX  == 5'd30);
  assign v_mem = RegWrite_MEM && !RPzero_MEM && |Rd_MEM && !(R30_GUARD && Rd_MEM == 5'd30);
  assign v_wb  = RegWrite_WB  && !RPzero_WB  && |Rd_WB  && !(R30_GUARD && Rd_WB  == 5'd30);
  always_comb begin
    ForwardA = !UseRs                  ? 2'b00 :
               (v_ex  && Rd_EX  == Rs) ? 2'b01 :
               (v_mem && Rd_MEM == Rs) ? 2'b10 :
               (v_wb  && Rd_WB  == Rs) ? 2'b11 : 2'b00;
    ForwardB = !UseRt                  ? 2'b00 :
               (v_ex  && Rd_EX  == Rt) ? 2'b01 :
               (v_mem && Rd_MEM == Rt) ? 2'b10 :
               (v_wb  && Rd_WB  == Rt) ? 2'b11 : 2'b00;
    Stall    = MemRead_EX && v_ex && ((UseRs && Rs == Rd_EX) || (UseRt && Rt == Rd_EX));
  end
  always_ff @(posedge clk)
    if (!rst_n) StallCount <= '0;
    else if (Stall && !(&StallCount)) StallCount <= StallCount + CNT_W'(1);
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed literal checks plus randomized stimulus against a rule-level model.
module tb_hazard_unit;
`ifdef HAZARD_R30_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs, Rt, Rd_EX, Rd_MEM, Rd_WB;
  logic UseRs, UseRt, RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemRead_EX;
  logic RPzero_EX, RPzero_MEM, RPzero_WB;
  logic [1:0] ForwardA, ForwardB, fa2, fb2;
  logic Stall, st2;
  logic [15:0] StallCount;
  logic [1:0] sc2;
  int passes = 0, total = 0, m_cnt = 0, m_cnt2 = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs(Rs), .Rt(Rt), .UseRs(UseRs), .UseRt(UseRt),
    .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX), .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall), .StallCount(StallCount)
  );

  hazard_unit #(.CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .Rs(Rs), .Rt(Rt), .UseRs(UseRs), .UseRt(UseRt),
    .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX), .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .ForwardA(fa2), .ForwardB(fb2), .Stall(st2), .StallCount(sc2)
  );

  // Producers indexed 0=EX,1=MEM,2=WB, which is also the priority order.
  function automatic bit m_prod(input int i);
    logic [4:0] rd;
    bit wr, sq;
    rd = (i == 0) ? Rd_EX : (i == 1) ? Rd_MEM : Rd_WB;
    wr = (i == 0) ? RegWrite_EX : (i == 1) ? RegWrite_MEM : RegWrite_WB;
    sq = (i == 0) ? RPzero_EX : (i == 1) ? RPzero_MEM : RPzero_WB;
    return wr && !sq && rd != 0 && !(GUARD && rd == 30);
  endfunction

  function automatic logic [1:0] m_fwd(input bit use_r, input logic [4:0] r);
    logic [4:0] rd[3];
    rd[0] = Rd_EX; rd[1] = Rd_MEM; rd[2] = Rd_WB;
    if (!use_r) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (m_prod(i) && rd[i] == r) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    return MemRead_EX && m_prod(0) && ((UseRs && Rs == Rd_EX) || (UseRt && Rt == Rd_EX));
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_cnt2 <= 0;
    end else if (m_stall()) begin
      m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    end
  end

  always @(negedge clk)
    if (en) begin
      chk("fwdA", 32'(ForwardA), 32'(m_fwd(UseRs, Rs)));
      chk("fwdB", 32'(ForwardB), 32'(m_fwd(UseRt, Rt)));
      chk("stall", 32'(Stall), 32'(m_stall()));
      chk("count", 32'(StallCount), 32'(m_cnt));
      chk("count_w2", 32'(sc2), 32'(m_cnt2));
    end

  task automatic idle();
    Rs = 0; Rt = 0; UseRs = 0; UseRt = 0; Rd_EX = 0; Rd_MEM = 0; Rd_WB = 0;
    RegWrite_EX = 0; RegWrite_MEM = 0; RegWrite_WB = 0; MemRead_EX = 0;
    RPzero_EX = 0; RPzero_MEM = 0; RPzero_WB = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_use();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 9; Rt = 9; UseRt = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    en = 1'b1;
    chk("reset_count", 32'(StallCount), 32'd0);
    rst_n = 1;
    step(); Rs = 5; UseRs = 1; Rd_EX = 5; RegWrite_EX = 1; Rd_MEM = 5; RegWrite_MEM = 1; #1;
    chk("ex_over_mem", 32'(ForwardA), 32'd1);
    chk("ex_over_mem_stall", 32'(Stall), 32'd0);
    step(); Rt = 7; UseRt = 1; Rd_MEM = 7; RegWrite_MEM = 1; Rd_WB = 7; RegWrite_WB = 1;
    Rd_EX = 7; RegWrite_EX = 1; RPzero_EX = 1; #1;
    chk("mem_sq_ex", 32'(ForwardB), 32'd2);
    step(); Rs = 3; UseRs = 1; Rd_WB = 3; RegWrite_WB = 1; #1;
    chk("wb_only", 32'(ForwardA), 32'd3);
    step(); Rs = 0; UseRs = 1; Rd_EX = 0; RegWrite_EX = 1; #1;
    chk("r0", 32'(ForwardA), 32'd0);
    step(); Rs = 3; Rd_WB = 3; RegWrite_WB = 1; UseRs = 0; #1;
    chk("users_gate", 32'(ForwardA), 32'd0);
    step(); Rs = 4; Rt = 4; UseRs = 1; UseRt = 1; Rd_MEM = 4; RegWrite_MEM = 1; #1;
    chk("same_src_a", 32'(ForwardA), 32'd2);
    chk("same_src_b", 32'(ForwardB), 32'd2);
    step(); load_use(); #1;
    chk("load_use", 32'(Stall), 32'd1);
    step(); load_use(); RPzero_EX = 1; #1;
    chk("load_squashed", 32'(Stall), 32'd0);
    step(); load_use(); UseRt = 0; #1;
    chk("load_unused", 32'(Stall), 32'd0);
    step(); Rs = 30; UseRs = 1; Rd_EX = 30; RegWrite_EX = 1; #1;
    chk("r30", 32'(ForwardA), GUARD ? 32'd0 : 32'd1);
    rst_n = 0;
    step();
    chk("count_clear", 32'(StallCount), 32'd0);
    rst_n = 1;
    load_use();
    repeat (3) @(posedge clk);
    #1;
    chk("count3", 32'(StallCount), 32'd3);
    chk("count3_w2", 32'(sc2), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("count5", 32'(StallCount), 32'd5);
    chk("sat_w2", 32'(sc2), 32'd3);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("reset_mid_stall", 32'(StallCount), 32'd0);
    chk("reset_mid_stall_w2", 32'(sc2), 32'd0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("restart", 32'(StallCount), 32'd1);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 59) != 0);
      Rs = ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 5));
      Rt = ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 5));
      Rd_EX = ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 5));
      Rd_MEM = 5'($urandom_range(0, 5));
      Rd_WB = ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 5));
      {UseRs, UseRt, RegWrite_EX, RegWrite_MEM, RegWrite_WB} = 5'($urandom);
      MemRead_EX = ($urandom_range(0, 1) == 0);
      RPzero_EX = ($urandom_range(0, 3) == 0);
      RPzero_MEM = ($urandom_range(0, 3) == 0);
      RPzero_WB = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Data-hazard unit for the 5-stage predicated pipeline.
- Sits in ID. Compares the decoding instruction's source registers (Rs, Rt) against the destinations in EX, MEM and WB.
- Produces the operand-forwarding selects used by the ID-stage A/B muxes, and a load-use Stall that freezes PC/IR and injects an ID/EX bubble.
- Keeps a registered saturating count of stall cycles for performance observation.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- Rs  input  5  source register A of the ID instruction.
- Rt  input  5  source register B of the ID instruction.
- UseRs  input  1  ID instruction reads Rs.
- UseRt  input  1  ID instruction reads Rt.
- Rd_EX  input  5  destination register in EX.
- Rd_MEM  input  5  destination register in MEM.
- Rd_WB  input  5  destination register in WB.
- RegWrite_EX  input  1  EX instruction writes a register.
- RegWrite_MEM  input  1  MEM instruction writes a register.
- RegWrite_WB  input  1  WB instruction writes a register.
- MemRead_EX  input  1  EX instruction is a load.
- RPzero_EX  input  1  EX instruction's predicate is false (squashed).
- RPzero_MEM  input  1  MEM instruction's predicate is false (squashed).
- RPzero_WB  input  1  WB instruction's predicate is false (squashed).
- ForwardA  output  2  A-operand select: 00 regfile, 01 EX, 10 MEM, 11 WB.
- ForwardB  output  2  B-operand select, same encoding as ForwardA.
- Stall  output  1  load-use stall request.
- StallCount  output  CNT_W  number of cycles in which Stall was 1.

Behaviour:
- Stage X (EX, MEM, WB) is a valid producer when all of the following hold:
  - RegWrite_X=1
  - RPzero_X=0
  - Rd_X != 0
- ForwardA:
  - Applies only when UseRs=1; otherwise ForwardA=00.
  - Fixed priority EX > MEM > WB:
    - 01 if EX is a valid producer and Rd_EX==Rs.
    - else 10 if MEM is a valid producer and Rd_MEM==Rs.
    - else 11 if WB is a valid producer and Rd_WB==Rs.
    - else 00.
- ForwardB: identical to ForwardA, using Rt and UseRt.
- Rs==Rt matching the same producer: both selects point at that producer.
- Stall=1 iff all of the following hold; otherwise Stall=0:
  - MemRead_EX=1
  - EX is a valid producer
  - (UseRs and Rs==Rd_EX) or (UseRt and Rt==Rd_EX)
- A squashed load (RPzero_EX=1) never stalls.
- ForwardA, ForwardB and Stall are purely combinational, with zero latency and no dependence on clk or rst_n.
- During Stall, the forward selects are still computed per the rules above. The selects are don't-care to the datapath because a bubble is injected.
- StallCount:
  - Updated on the rising edge of clk.
  - If rst_n=0, clears to 0. Reset asserted mid-stall still clears; a new count starts on the first post-reset edge with Stall=1.
  - Else if Stall=1 and StallCount != all-ones, increments by 1.
  - Saturates at 2^CNT_W-1 and holds.
  - Reset value 0.
- No other state exists; combinational outputs have no reset value.

Optional Feature:
- Macro: HAZARD_R30_GUARD_EN.
- Defined: the valid-producer condition additionally requires Rd_X != 30. R30 is hardwired in the register file, so writes to it are never forwarded and never cause a stall.
- Undefined: Rd_X==30 is treated like any other nonzero register.

Test Plan:
- EX/MEM priority:
  - Stimulus: Rs=5, UseRs=1, Rd_EX=5, RegWrite_EX=1, Rd_MEM=5, RegWrite_MEM=1, all RPzero=0, MemRead_EX=0.
  - Required: ForwardA=01, Stall=0.
- MEM/WB with squashed EX:
  - Stimulus: Rt=7, UseRt=1, Rd_MEM=7, RegWrite_MEM=1, Rd_WB=7, RegWrite_WB=1, Rd_EX=7, RegWrite_EX=1, RPzero_EX=1.
  - Required: ForwardB=10.
- R0 and UseRs gating:
  - Stimulus: Rs=0, Rd_EX=0, RegWrite_EX=1.
  - Required: ForwardA=00.
  - Stimulus: Rs=3, Rd_WB=3, RegWrite_WB=1, UseRs=0.
  - Required: ForwardA=00.
- Load-use stall:
  - Stimulus: MemRead_EX=1, RegWrite_EX=1, Rd_EX=9, Rt=9, UseRt=1.
  - Required: Stall=1.
  - Same but RPzero_EX=1 → Stall=0.
  - Same but UseRt=0 → Stall=0.
- Counter:
  - Reset with rst_n=0 for 1 edge → StallCount=0.
  - Hold Stall=1 for 3 edges → StallCount=3.
  - With CNT_W=2, hold Stall=1 for 5 edges → StallCount=3 (saturated).
  - Assert rst_n=0 while Stall=1 → StallCount=0 next edge.
- Macro:
  - Stimulus: Rs=30, UseRs=1, Rd_EX=30, RegWrite_EX=1.
  - Required: ForwardA=01 without HAZARD_R30_GUARD_EN; ForwardA=00 with it.
